aes_key_expand: RTL
===================

# aes_key_expand

Iterative AES-128 key-schedule generator that sits directly upstream of the aes round datapath. It accepts a 128-bit cipher key and emits round keys 0..10, one per accepted beat, on a valid/ready stream. Each key is in the same column-major byte order as the datapath's key operand (byte 0 = bits [127:120]). One S-box lookup of four bytes is performed per round, and the block holds only the current round key.

## Interface
- No parameters (AES-128 only; Nk=4, Nr=10 fixed).
- clk  in  1  system clock, rising-edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  request expansion of key_in; sampled only in IDLE
- key_in  in  128  cipher key; w0 = [127:96], w3 = [31:0]
- rk_ready  in  1  downstream accepts current round key this cycle
- rk_valid  out  1  round_key/round_num are valid
- round_num  out  4  index of presented key, 0..10
- round_key  out  128  round key for round_num
- rk_last  out  1  rk_valid && round_num==10 (combinational from registers)
- busy  out  1  high in EXPAND state

## Operation
- FSM states: IDLE, EXPAND.
- IDLE to EXPAND when start=1: key_reg<=key_in, round<=0.
- EXPAND, rk_ready=1, round<10: key_reg<=next_key(key_reg, rcon[round]), round<=round+1.
- EXPAND, rk_ready=1, round==10: return to IDLE; key_reg and round hold their values.
- EXPAND, rk_ready=0: all registers hold, giving a full stall with the output stable.
- next_key, with words w0..w3 of key_reg:
  - t = SubWord(RotWord(w3)) ^ {rcon,24'h0}
  - w0'=w0^t, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'
- RotWord: {b1,b2,b3,b0}. SubWord: the standard AES S-box on each byte.
- rcon by round 0..9: 01,02,04,08,10,20,40,80,1b,36.
- round_key = key_reg; round_num = round; rk_valid = busy = (state==EXPAND).
- start while busy is ignored. key_in is sampled only on the accepting edge and may change afterwards.

## Timing
- Reset (async, rst=0): state=IDLE, key_reg=0, round=0.
  - Outputs: rk_valid=0, busy=0, rk_last=0, round_num=0, round_key=0.
- start sampled high at edge N: rk_valid=1 with round 0 (= key_in) in cycle N+1.
- Each key is accepted on an edge where rk_valid&&rk_ready. The next key appears in the following cycle, so throughput is 1 key/cycle.
- With rk_ready tied high: rounds 0..10 are presented in 11 consecutive cycles, N+1..N+11. busy falls after edge N+11.
- A new start is sampled earliest at edge N+12; start at edge N+11 is ignored.
- Reset asserted mid-expansion: everything clears immediately (async). After release, the block sits in IDLE until the next start.
- rk_ready high in the same cycle rk_valid rises: round 0 is consumed at the next edge. There is no extra bubble.

## Test plan
- Reset: hold rst=0 with start=1 and random key_in.
  - Required: rk_valid=0, busy=0, round_key=0 throughout.
  - After release with start=0: outputs stay idle.
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1, expected keys:
  - round 0: the key itself
  - round 1: a0fafe1788542cb123a339392a6c7605
  - round 10: d014f9a8c9ee2589e13f0cc8b6630ca6
  - rk_last high only on cycle N+11.
- All-zero key, expected keys:
  - round 1: 62636363626363636263636362636363
  - round 2: 9b9898c9f9fbfbaa9b9898c9f9fbfbaa
  - round 10: b4ef5bcb3e92e21123e951cf6f8f188e
- Backpressure: FIPS key, rk_ready random at about 40% duty.
  - Identical 11-key sequence; no skipped or duplicated round_num.
  - round_key stable whenever rk_valid&&!rk_ready.
- start re-asserted with a different key during EXPAND and at the round-10 edge.
  - Required: both ignored; the original sequence completes.
  - A start one cycle after busy falls begins the new key's round 0.
- rst pulsed low mid-stream at round 5:
  - Required: immediate rk_valid=0, round_num=0.
  - A subsequent start with the zero key yields the correct full sequence.

Source files
------------

// File: rtl/aes_key_expand_if.sv
// rtl/aes_key_expand_if.sv - start/key request and round-key stream bundle for aes_key_expand
interface aes_key_expand_if;
    logic         start;
    logic [127:0] key_in;
    logic         rk_ready;
    logic         rk_valid;
    logic [3:0]   round_num;
    logic [127:0] round_key;
    logic         rk_last;
    logic         busy;

    modport master (
        output start, key_in, rk_ready,
        input  rk_valid, round_num, round_key, rk_last, busy
    );

    modport slave (
        input  start, key_in, rk_ready,
        output rk_valid, round_num, round_key, rk_last, busy
    );
endinterface

// File: rtl/aes_key_expand.sv
// rtl/aes_key_expand.sv - iterative AES-128 key schedule, one round key per accepted beat
module aes_key_expand (
    input  logic              clk,
    input  logic              rst,
    aes_key_expand_if.slave   bus
);

    localparam logic [3:0] LAST_ROUND = 4'd10;

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_EXPAND = 1'b1
    } state_t;

    state_t       state;
    state_t       state_nxt;
    logic [127:0] key_reg;
    logic [3:0]   round;
    logic         load_key;
    logic         advance;
    logic         in_expand;

    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  t_word;
    logic [31:0]  n0, n1, n2, n3;

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] c;
        case (r)
            4'd0:    c = 8'h01;
            4'd1:    c = 8'h02;
            4'd2:    c = 8'h04;
            4'd3:    c = 8'h08;
            4'd4:    c = 8'h10;
            4'd5:    c = 8'h20;
            4'd6:    c = 8'h40;
            4'd7:    c = 8'h80;
            4'd8:    c = 8'h1b;
            4'd9:    c = 8'h36;
            default: c = 8'h00;
        endcase
        return c;
    endfunction

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic; start is only looked at while idle
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    state_nxt = S_EXPAND;
                end
            end
            S_EXPAND: begin
                if (bus.rk_ready && (round == LAST_ROUND)) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs: load and advance strobes for the datapath
    always_comb begin
        load_key  = 1'b0;
        advance   = 1'b0;
        in_expand = 1'b0;
        case (state)
            S_IDLE: begin
                load_key = bus.start;
            end
            S_EXPAND: begin
                in_expand = 1'b1;
                advance   = bus.rk_ready && (round != LAST_ROUND);
            end
            default: begin
                load_key  = 1'b0;
                advance   = 1'b0;
                in_expand = 1'b0;
            end
        endcase
    end

    assign w0 = key_reg[127:96];
    assign w1 = key_reg[95:64];
    assign w2 = key_reg[63:32];
    assign w3 = key_reg[31:0];

    // RotWord moves the top byte of w3 to the bottom before substitution
    assign t_word = sub_word({w3[23:0], w3[31:24]}) ^ {rcon(round), 24'h000000};
    assign n0     = w0 ^ t_word;
    assign n1     = w1 ^ n0;
    assign n2     = w2 ^ n1;
    assign n3     = w3 ^ n2;

    // Only the current round key is held; after round 10 it stays until the next load
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_reg <= '0;
            round   <= '0;
        end else if (load_key) begin
            key_reg <= bus.key_in;
            round   <= '0;
        end else if (advance) begin
            key_reg <= {n0, n1, n2, n3};
            round   <= round + 4'd1;
        end
    end

    assign bus.rk_valid  = in_expand;
    assign bus.busy      = in_expand;
    assign bus.round_num = round;
    assign bus.round_key = key_reg;
    assign bus.rk_last   = in_expand && (round == LAST_ROUND);

endmodule
